// File: rtl/quad_step_decoder_if.sv
// Quadrature encoder signal bundle: raw A/B levels toward the decoder,
// step pulse, direction and illegal-jump flag back from it.
interface quad_step_decoder_if;
    logic a_in;
    logic b_in;
    logic e_out;
    logic f_out;
    logic err;

    modport master (
        output a_in,
        output b_in,
        input  e_out,
        input  f_out,
        input  err
    );

    modport slave (
        input  a_in,
        input  b_in,
        output e_out,
        output f_out,
        output err
    );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature A/B to step/direction front end: 2-flop sync, 3-edge init, Gray decode.
// Define QDEC_DEBOUNCE_EN to add per-channel debounce of DEBOUNCE_CYCLES stable edges.
module quad_step_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    quad_step_decoder_if.slave qdec
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_param_check
        $error("DEBOUNCE_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        S_INIT0,
        S_INIT1,
        S_INIT2,
        S_RUN
    } state_t;

    state_t     r_state;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_stable;
    logic       r_e;
    logic       r_f;
    logic       r_err;

    logic [1:0] w_next_stable;
    logic       w_change;
    logic       w_both;
    logic       w_fwd;

`ifdef QDEC_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt      [2];
    logic [CNT_W-1:0] w_cnt_next [2];

    // A channel's stable bit flips only after DEBOUNCE_CYCLES consecutive disagreeing edges.
    always_comb begin
        w_next_stable = r_stable;
        for (int unsigned i = 0; i < 2; i++) begin
            w_cnt_next[i] = '0;
            if (r_sync2[i] != r_stable[i]) begin
                if (r_cnt[i] + CNT_W'(1) == CNT_W'(DEBOUNCE_CYCLES)) begin
                    w_next_stable[i] = r_sync2[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end
`else
    always_comb begin
        w_next_stable = r_sync2;
    end
`endif

    // Bit 1 is A, bit 0 is B; with a single-bit change, forward means new = {~old.B, old.A}.
    always_comb begin
        w_change = (w_next_stable != r_stable);
        w_both   = &(w_next_stable ^ r_stable);
        w_fwd    = (w_next_stable == {~r_stable[0], r_stable[1]});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_INIT0;
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_e      <= 1'b0;
            r_f      <= 1'b0;
            r_err    <= 1'b0;
`ifdef QDEC_DEBOUNCE_EN
            for (int unsigned i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
`endif
        end else begin
            r_sync1 <= {qdec.a_in, qdec.b_in};
            r_sync2 <= r_sync1;
            case (r_state)
                S_RUN: begin
                    r_stable <= w_next_stable;
                    r_e      <= w_change & ~w_both;
                    r_err    <= w_both;
                    if (w_change && !w_both) begin
                        r_f <= w_fwd;
                    end
`ifdef QDEC_DEBOUNCE_EN
                    for (int unsigned i = 0; i < 2; i++) begin
                        r_cnt[i] <= w_cnt_next[i];
                    end
`endif
                end
                default: begin
                    // Track the resting position so a non-00 start yields no step or err.
                    r_stable <= r_sync2;
                    r_e      <= 1'b0;
                    r_err    <= 1'b0;
                    case (r_state)
                        S_INIT0: r_state <= S_INIT1;
                        S_INIT1: r_state <= S_INIT2;
                        default: r_state <= S_RUN;
                    endcase
`ifdef QDEC_DEBOUNCE_EN
                    for (int unsigned i = 0; i < 2; i++) begin
                        r_cnt[i] <= '0;
                    end
`endif
                end
            endcase
        end
    end

    assign qdec.e_out = r_e;
    assign qdec.f_out = r_f;
    assign qdec.err   = r_err;

endmodule
